slc3_control_fsm: RTL
=====================

Name: slc3_control_fsm

Overview:
- Moore-style instruction sequencer for the SLC-3 datapath. Drives every load enable, bus gate, mux select and ALU op the datapath consumes, plus memory strobes.
- Runs fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PSE.
- Sits between the top level (Run/Continue switches, SRAM strobes) and the datapath. Takes IR fields and BEN back from the datapath.

Parameters:
- MEM_WAIT, 2, cycles each memory read/write state is held (legal range ≥1).

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high reset
- Run  in  1  leave HALTED and start fetching
- Continue  in  1  release from PSE pause
- Opcode  in  4  IR[15:12]
- IR_5  in  1  IR[5], imm/reg select for ADD/AND
- IR_11  in  1  IR[11], JSR flag (JSRR unsupported, ignored)
- BEN  in  1  branch-enable from datapath
- LD_MAR, LD_PC, LD_MDR, LD_IR, LD_CC, LD_BEN, LD_REG, LD_LED  out  1 each  register loads
- GatePC, GateMDR, GateMARMUX, GateALU  out  1 each  bus drivers; at most one high
- PCMUX  out  2  00 PC+1, 01 BUS, 10 address adder
- ADDR2MUX  out  2  00 zero, 01 off6, 10 off9, 11 off11
- ALUK  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS
- MIO_EN, DRMUX, SR1MUX, ADDR1MUX, SR2MUX  out  1 each  see Behaviour
- Mem_OE, Mem_WE  out  1 each  active-high memory read/write strobes
- State  out  5  current state code, for debug display

Behaviour:
- Clock and reset: single clock Clk. Reset is asynchronous and active-high. Reset forces state HALTED and clears the wait counter.
- Outputs: all outputs are decoded combinationally from state only (Moore), so Reset drives them to 0 immediately. Every output is 0 in any state unless listed below.
- Select encodings:
  - DRMUX: 0 = IR[11:9], 1 = R7.
  - SR1MUX: 0 = IR[11:9], 1 = IR[8:6].
  - ADDR1MUX: 0 = PC, 1 = SR1.
  - SR2MUX: 0 = register, 1 = imm5.
  - MIO_EN: 0 = BUS, 1 = memory.
- HALTED: stay while Run=0; Run=1 -> S18.
- S18: GatePC, LD_MAR, LD_PC, PCMUX=00 -> S33.
- S33: Mem_OE, MIO_EN=1, LD_MDR; held MEM_WAIT cycles -> S35.
- S35: GateMDR, LD_IR -> S32.
- S32: LD_BEN; branch on Opcode:
  - 0001 -> S1
  - 0101 -> S5
  - 1001 -> S9
  - 0000 -> S0
  - 1100 -> S12
  - 0100 -> S4
  - 0110 -> S6
  - 0111 -> S7
  - 1101 -> PAUSE1
  - any other -> S18 (instruction treated as NOP)
- S1 (ADD): SR1MUX=1, SR2MUX=IR_5, ALUK=00, GateALU, DRMUX=0, LD_REG, LD_CC -> S18.
- S5 (AND): as S1 with ALUK=01.
- S9 (NOT): SR1MUX=1, ALUK=10, GateALU, LD_REG, LD_CC -> S18.
- S0: BEN=1 -> S22, else -> S18.
- S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
- S12 (JMP): SR1MUX=1, ALUK=11, GateALU, PCMUX=01, LD_PC -> S18.
- S4: DRMUX=1, GatePC, LD_REG -> S21.
- S21: ADDR1MUX=0, ADDR2MUX=11, PCMUX=10, LD_PC -> S18. The R7 write in S4 uses the already-incremented PC.
- S6: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S25.
- S25: as S33 (MEM_WAIT cycles) -> S27.
- S27: GateMDR, DRMUX=0, LD_REG, LD_CC -> S18.
- S7: as S6 -> S23.
- S23: SR1MUX=0, ALUK=11, GateALU, MIO_EN=0, LD_MDR -> S16.
- S16: Mem_WE, held MEM_WAIT cycles -> S18.
- PAUSE1: LD_LED; stay while Continue=0 -> PAUSE2.
- PAUSE2: stay while Continue=1 -> S18. One Continue press releases exactly once.
- Wait counter: 0..MEM_WAIT-1. Cleared on entry to S33/S25/S16. Exit the state when count==MEM_WAIT-1. MEM_WAIT=1 gives a one-cycle state.
- Run during execution: ignored.
- Reset mid-STR: Mem_WE deasserts asynchronously; no further strobes until Run.
- Fetch latency: Run accepted at edge t → S18 at t, first execute state at t+3+MEM_WAIT.

Optional Feature:
- Macro SLC3_CTRL_PERF_EN.
- Defined: adds output Retired[15:0], incremented on every transition into S18 from an execute or PAUSE2 state. Wraps FFFF→0000. Reset clears it to 0.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package slc3_ctrl_pkg holds:
  - state_t enum with fixed 5-bit codes matching the LC-3 state numbers (HALTED=5'h1F, PAUSE1=5'h1D, PAUSE2=5'h1E);
  - opcode localparams;
  - PCMUX/ADDR2MUX/ALUK encoding localparams.
- Sub-module mem_wait_counter (clear, enable, done) holds the MEM_WAIT counter.

Test Plan:
- Reset asserted mid-cycle → State=5'h1F, all outputs 0 without waiting for Clk. Run=1 for 1 cycle → next cycle State=18, GatePC=LD_MAR=LD_PC=1, PCMUX=00.
- MEM_WAIT=2, Opcode=0001, IR_5=1 → S33 held exactly 2 cycles, S1 on 6th cycle after Run, with SR2MUX=1, ALUK=00, GateALU=LD_REG=LD_CC=1, SR1MUX=1, DRMUX=0.
- Opcode=0000: BEN=0 → S32→S0→S18 with LD_PC never high in S0. BEN=1 → S22 with PCMUX=10, ADDR2MUX=10, ADDR1MUX=0, LD_PC=1.
- Opcode=0111, MEM_WAIT=3 → S7, S23 (ALUK=11, LD_MDR, MIO_EN=0), then Mem_WE high exactly 3 cycles. Reset pulse during S16 → Mem_WE low immediately.
- Opcode=1101 → PAUSE1 with LD_LED=1 held 10 cycles with Continue=0. Continue=1 for 4 cycles → PAUSE2 for those cycles. Continue=0 → S18 once.
- Opcode=1010 (illegal) → S32→S18, no LD_REG/LD_PC/Mem_WE asserted. With SLC3_CTRL_PERF_EN, Retired increments by 1 per ADD, and by 0 for the illegal opcode.

Source files
------------

// File: rtl/slc3_ctrl_pkg.sv
// SLC-3 control sequencer shared types: state codes, opcodes, mux encodings.
// Optional build macro SLC3_CTRL_PERF_EN is consumed by slc3_control_fsm.
package slc3_ctrl_pkg;

  // LC-3 states 32/33/35 do not fit in 5 bits; they use free codes
  typedef enum logic [4:0] {
    S0     = 5'd0,
    S1     = 5'd1,
    S4     = 5'd4,
    S5     = 5'd5,
    S6     = 5'd6,
    S7     = 5'd7,
    S9     = 5'd9,
    S12    = 5'd12,
    S16    = 5'd16,
    S18    = 5'd18,
    S21    = 5'd21,
    S22    = 5'd22,
    S23    = 5'd23,
    S25    = 5'd25,
    S27    = 5'd27,
    S35    = 5'h18,
    S33    = 5'h1A,
    S32    = 5'h1C,
    PAUSE1 = 5'h1D,
    PAUSE2 = 5'h1E,
    HALTED = 5'h1F
  } state_t;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_JSR = 4'b0100;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_PSE = 4'b1101;

  localparam logic [1:0] PC_INC  = 2'b00;
  localparam logic [1:0] PC_BUS  = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;

  localparam logic [1:0] A2_ZERO  = 2'b00;
  localparam logic [1:0] A2_OFF6  = 2'b01;
  localparam logic [1:0] A2_OFF9  = 2'b10;
  localparam logic [1:0] A2_OFF11 = 2'b11;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_AND  = 2'b01;
  localparam logic [1:0] ALU_NOT  = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  function automatic logic is_mem_state(input state_t s);
    return (s == S33) || (s == S25) || (s == S16);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Counts cycles spent in a memory access state; done on the last one.
// Held at zero while clear is high so every access starts from 0.
module mem_wait_counter #(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int unsigned CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_WAIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !done) begin
      count <= count + CW'(1);
    end
  end

  assign done = (count == LAST);

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 Moore control sequencer: fetch/decode/execute for the datapath.
// `define SLC3_CTRL_PERF_EN adds the Retired instruction counter port.
module slc3_control_fsm
  import slc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_PC,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_CC,
  output logic       LD_BEN,
  output logic       LD_REG,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateMARMUX,
  output logic       GateALU,
  output logic [1:0] PCMUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       MIO_EN,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       ADDR1MUX,
  output logic       SR2MUX,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [4:0] State
`ifdef SLC3_CTRL_PERF_EN
  ,output logic [15:0] Retired
`endif
);

  state_t state;
  state_t nxt;
  logic   mem_done;
  logic   unused_ir11;

  // JSRR is not supported, so the JSR/JSRR flag has no effect
  assign unused_ir11 = IR_11;

  mem_wait_counter #(
    .MEM_WAIT(MEM_WAIT)
  ) u_wait (
    .clk   (Clk),
    .rst   (Reset),
    .clear (!is_mem_state(state)),
    .enable(is_mem_state(state)),
    .done  (mem_done)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      HALTED: if (Run) nxt = S18;
      S18:    nxt = S33;
      S33:    if (mem_done) nxt = S35;
      S35:    nxt = S32;
      S32: begin
        case (Opcode)
          OP_ADD:  nxt = S1;
          OP_AND:  nxt = S5;
          OP_NOT:  nxt = S9;
          OP_BR:   nxt = S0;
          OP_JMP:  nxt = S12;
          OP_JSR:  nxt = S4;
          OP_LDR:  nxt = S6;
          OP_STR:  nxt = S7;
          OP_PSE:  nxt = PAUSE1;
          default: nxt = S18;
        endcase
      end
      S1, S5, S9, S12, S21, S22, S27: nxt = S18;
      S0:     nxt = BEN ? S22 : S18;
      S4:     nxt = S21;
      S6:     nxt = S25;
      S25:    if (mem_done) nxt = S27;
      S7:     nxt = S23;
      S23:    nxt = S16;
      S16:    if (mem_done) nxt = S18;
      PAUSE1: if (Continue) nxt = PAUSE2;
      PAUSE2: if (!Continue) nxt = S18;
      default: nxt = HALTED;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= HALTED;
    end else begin
      state <= nxt;
    end
  end

  assign State = state;

`ifdef SLC3_CTRL_PERF_EN
  // Returning to fetch from anywhere but HALTED or decode retires one
  logic retire;
  assign retire = (nxt == S18) && (state != HALTED) && (state != S32);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Retired <= '0;
    end else if (retire) begin
      Retired <= Retired + 16'd1;
    end
  end
`endif

  always_comb begin
    LD_MAR     = 1'b0;
    LD_PC      = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_CC      = 1'b0;
    LD_BEN     = 1'b0;
    LD_REG     = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateMARMUX = 1'b0;
    GateALU    = 1'b0;
    PCMUX      = PC_INC;
    ADDR2MUX   = A2_ZERO;
    ALUK       = ALU_ADD;
    MIO_EN     = 1'b0;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    SR2MUX     = 1'b0;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = PC_INC;
      end
      S33, S25: begin
        Mem_OE = 1'b1;
        MIO_EN = 1'b1;
        LD_MDR = 1'b1;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S1, S5: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S5) ? ALU_AND : ALU_ADD;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S9: begin
        SR1MUX  = 1'b1;
        ALUK    = ALU_NOT;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S22: begin
        ADDR2MUX = A2_OFF9;
        PCMUX    = PC_ADDR;
        LD_PC    = 1'b1;
      end
      S12: begin
        SR1MUX  = 1'b1;
        ALUK    = ALU_PASS;
        GateALU = 1'b1;
        PCMUX   = PC_BUS;
        LD_PC   = 1'b1;
      end
      S4: begin
        DRMUX  = 1'b1;
        GatePC = 1'b1;
        LD_REG = 1'b1;
      end
      S21: begin
        ADDR2MUX = A2_OFF11;
        PCMUX    = PC_ADDR;
        LD_PC    = 1'b1;
      end
      S6, S7: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = A2_OFF6;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S23: begin
        ALUK    = ALU_PASS;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S16:    Mem_WE = 1'b1;
      PAUSE1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule
